// File: rtl/io_ring_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : io_ring_pwr_seq                                           |
// | Function : IO-ring power-up sequencer. Debounces the IO supply-good  |
// |            flag, then steps through bias, filter settle and pad      |
// |            retention release before allowing pad output enables.     |
// |            Loss of supply at any active step gives a sticky fault.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module io_ring_pwr_seq #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned T_DEB    = 64,
   parameter int unsigned T_BIAS   = 1000,
   parameter int unsigned T_SETTLE = 4000,
   parameter int unsigned T_REL    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_pwr_ok,
   input  logic       seq_start,
   input  logic       fault_clr,
   output logic       bias_en,
   output logic       pad_ret,
   output logic       pad_oe_allow,
   output logic       seq_done,
   output logic       fault,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_DEB     = 3'd1,
      S_BIAS    = 3'd2,
      S_SETTLE  = 3'd3,
      S_RELEASE = 3'd4,
      S_READY   = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   // Largest count representable by the delay counter.
   localparam logic [63:0] c_CNT_MAX = (CNT_W >= 64) ? {64{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

   // A zero delay or one the counter cannot reach is a build error.
   if (CNT_W == 0 || T_DEB == 0 || T_BIAS == 0 || T_SETTLE == 0 || T_REL == 0 ||
       64'(T_DEB) > c_CNT_MAX || 64'(T_BIAS) > c_CNT_MAX ||
       64'(T_SETTLE) > c_CNT_MAX || 64'(T_REL) > c_CNT_MAX) begin : g_param_err
      $error("io_ring_pwr_seq: T_* parameters must be nonzero and fit in CNT_W bits");
   end

   // Counter value seen during the last cycle of each timed state.
   localparam logic [CNT_W-1:0] c_DEB_LAST    = CNT_W'(T_DEB - 1);
   localparam logic [CNT_W-1:0] c_BIAS_LAST   = CNT_W'(T_BIAS - 1);
   localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(T_SETTLE - 1);
   localparam logic [CNT_W-1:0] c_REL_LAST    = CNT_W'(T_REL - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic               pok_meta_q, pok_s_q;
   logic               bias_en_q, bias_en_d;
   logic               pad_ret_q, pad_ret_d;
   logic               pad_oe_q, pad_oe_d;
   logic               seq_done_q, seq_done_d;
   logic               fault_q, fault_d;

   // Two-flop synchroniser for the asynchronous supply-good flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pok_meta_q <= 1'b0;
         pok_s_q    <= 1'b0;
      end else begin
         pok_meta_q <= io_pwr_ok;
         pok_s_q    <= pok_meta_q;
      end
   end

   // Saturating increment so an over-long phase can never wrap the count.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + c_CNT_ONE;

   // Next state, next count and next registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (seq_start && pok_s_q) state_d = S_DEB;
         end
         S_DEB: begin
            // A supply glitch only restarts the debounce window.
            if (!pok_s_q)                  cnt_d   = '0;
            else if (cnt_q == c_DEB_LAST)  state_d = S_BIAS;
            else                           cnt_d   = cnt_inc;
         end
         S_BIAS: begin
            if (!pok_s_q)                  state_d = S_FAULT;
            else if (cnt_q == c_BIAS_LAST) state_d = S_SETTLE;
            else                           cnt_d   = cnt_inc;
         end
         S_SETTLE: begin
            if (!pok_s_q)                    state_d = S_FAULT;
            else if (cnt_q == c_SETTLE_LAST) state_d = S_RELEASE;
            else                             cnt_d   = cnt_inc;
         end
         S_RELEASE: begin
            if (!pok_s_q)                 state_d = S_FAULT;
            else if (cnt_q == c_REL_LAST) state_d = S_READY;
            else                          cnt_d   = cnt_inc;
         end
         S_READY: begin
            if (!pok_s_q) state_d = S_FAULT;
         end
         S_FAULT: begin
            if (fault_clr) state_d = S_OFF;
         end
         default: state_d = S_OFF;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Outputs follow the state being entered, so they change on the
      // same edge as the state register.
      bias_en_d  = (state_d == S_BIAS) || (state_d == S_SETTLE) ||
                   (state_d == S_RELEASE) || (state_d == S_READY);
      pad_ret_d  = !((state_d == S_RELEASE) || (state_d == S_READY));
      pad_oe_d   = (state_d == S_READY);
      seq_done_d = (state_d == S_READY);
      fault_d    = (state_d == S_FAULT);
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_OFF;
         cnt_q      <= '0;
         bias_en_q  <= 1'b0;
         pad_ret_q  <= 1'b1;
         pad_oe_q   <= 1'b0;
         seq_done_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bias_en_q  <= bias_en_d;
         pad_ret_q  <= pad_ret_d;
         pad_oe_q   <= pad_oe_d;
         seq_done_q <= seq_done_d;
         fault_q    <= fault_d;
      end
   end

   assign bias_en      = bias_en_q;
   assign pad_ret      = pad_ret_q;
   assign pad_oe_allow = pad_oe_q;
   assign seq_done     = seq_done_q;
   assign fault        = fault_q;
   assign state_o      = state_q;

endmodule
`default_nettype wire

// File: doc/io_ring_pwr_seq.md
IO_RING_PWR_SEQ -- requirements
Module: io_ring_pwr_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all delay counters.
REQ-002 SHALL have parameter T_DEB, default 64, number of cycles io_pwr_ok must be stable high before sequencing starts.
REQ-003 SHALL have parameter T_BIAS, default 1000, number of cycles bias_en is held before the filter-settle phase.
REQ-004 SHALL have parameter T_SETTLE, default 4000, number of cycles allowed for well-filter settling.
REQ-005 SHALL have parameter T_REL, default 16, number of cycles between retention release and pad output enable.
REQ-006 SHALL have the following ports, one per line:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- io_pwr_ok  in  1  asynchronous IO-supply-good flag
- seq_start  in  1  one-cycle request to begin power-up
- fault_clr  in  1  one-cycle clear of sticky fault
- bias_en  out  1  enables well-filter bias
- pad_ret  out  1  pad retention; 1 = pads frozen
- pad_oe_allow  out  1  permits functional pad output enables
- seq_done  out  1  level, sequence complete
- fault  out  1  sticky supply-loss indicator
- state_o  out  3  current FSM state encoding, for debug

Function
REQ-007 SHALL synchronise io_pwr_ok through two flip-flops on clk; all logic SHALL use only the synchronised value pok_s.
REQ-008 SHALL implement states, encoded on state_o as: OFF=0, DEB=1, BIAS=2, SETTLE=3, RELEASE=4, READY=5, FAULT=6.
REQ-009 In OFF, a seq_start pulse with pok_s=1 SHALL move to DEB; a seq_start pulse with pok_s=0 SHALL be ignored.
REQ-010 In DEB, the counter SHALL increment while pok_s=1 and SHALL clear to 0 when pok_s=0, without leaving DEB; on the cycle the count reaches T_DEB-1, the FSM SHALL move to BIAS.
REQ-011 On entry to BIAS, the FSM SHALL assert bias_en, and bias_en SHALL then stay high in BIAS, SETTLE, RELEASE and READY.
REQ-012 BIAS SHALL last exactly T_BIAS cycles, SETTLE exactly T_SETTLE cycles, and RELEASE exactly T_REL cycles.
REQ-013 The counter SHALL clear to 0 on every state transition.
REQ-014 pad_ret SHALL be 1 in every state except RELEASE and READY.
REQ-015 pad_oe_allow and seq_done SHALL be 1 only in READY.
REQ-016 From DEB, BIAS, SETTLE, RELEASE or READY, pok_s=0 SHALL cause a move to FAULT on the next edge; this rule SHALL take priority over counter expiry and seq_start in the same cycle, except in DEB (see REQ-010).
REQ-017 Entry to FAULT SHALL, in the same registered update, set fault=1, pad_ret=1, pad_oe_allow=0, seq_done=0 and bias_en=0.
REQ-018 FAULT SHALL move to OFF only when fault_clr=1; fault SHALL clear in that same cycle.
REQ-019 fault_clr SHALL be ignored in every state other than FAULT.
REQ-020 seq_start SHALL be ignored in every state other than OFF.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-022 The counter SHALL be CNT_W bits wide and SHALL saturate rather than wrap.
REQ-023 Elaboration SHALL fail if any T_* parameter is 0 or does not fit in CNT_W bits.
REQ-024 Latency from the seq_start edge to pad_oe_allow=1, with pok_s already stable high, SHALL be exactly T_DEB+T_BIAS+T_SETTLE+T_REL+1 cycles.

Reset
REQ-025 While rst=1 at a clk edge, the FSM SHALL go to OFF, the counter and synchroniser SHALL clear to 0, and the outputs SHALL take the values bias_en=0, pad_ret=1, pad_oe_allow=0, seq_done=0, fault=0, state_o=0.
REQ-026 rst asserted mid-sequence, including in FAULT, SHALL override every other input and take effect at the next edge.
REQ-027 After reset, the block SHALL stay in OFF until a new seq_start; the sticky fault SHALL NOT survive reset.

Verification
REQ-028 Nominal run, using T_DEB=4, T_BIAS=8, T_SETTLE=10, T_REL=2: io_pwr_ok=1 held, then a seq_start pulse -> bias_en rises at edge 5, pad_ret falls at edge 23, pad_oe_allow and seq_done rise at edge 25; the bench SHALL also check every state_o value in turn.
REQ-029 Debounce restart: io_pwr_ok drops for 1 cycle at DEB count 2 -> FSM stays in DEB, the counter restarts, and bias_en is delayed by the full T_DEB.
REQ-030 Supply loss in SETTLE: io_pwr_ok=0 -> state_o=6 and fault=1 three edges after the drop (two synchroniser edges plus one FSM edge), with bias_en=0, pad_ret=1 and pad_oe_allow=0 in the same cycle.
REQ-031 Fault hold and clear: in FAULT, a seq_start pulse -> no change; then a fault_clr pulse -> state_o=0 and fault=0 on the next edge; a subsequent seq_start pulse restarts the sequence.
REQ-032 Simultaneous events: pok_s falls in the final RELEASE cycle -> FSM enters FAULT, not READY, and pad_oe_allow never pulses.
REQ-033 Reset in READY: rst=1 for 1 cycle -> all outputs return to their REQ-025 values on the next edge.
